// File: rtl/tiny_riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding, request decode helpers.
package tiny_riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_ISSUE = 2'd1,
    ST_LD_WAIT  = 2'd2,
    ST_ST_ISSUE = 2'd3
  } lsu_state_e;

  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords keep only addr[1], words always start at lane 0.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/tiny_riscv_lsu_if.sv
// CPU request/response and data-memory bus of the LSU; slave = LSU view, master = CPU + memory view.
interface tiny_riscv_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req;
  logic                  i_we;
  logic [2:0]            i_funct3;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [31:0]           i_wdata;
  logic                  o_ready;
  logic                  o_done;
  logic                  o_fault;
  logic [31:0]           o_rdata;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_read_strobe;
  logic [31:0]           o_mem_write_data;
  logic [3:0]            o_mem_write_mask;
  logic [31:0]           i_mem_data;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_data,
    output o_ready, o_done, o_fault, o_rdata, o_mem_addr, o_read_strobe,
           o_mem_write_data, o_mem_write_mask
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_data,
    input  o_ready, o_done, o_fault, o_rdata, o_mem_addr, o_read_strobe,
           o_mem_write_data, o_mem_write_mask
  );
endinterface

// File: rtl/tiny_riscv_lsu_align.sv
// Byte-lane steering: store mask/replicated data, load extract with sign/zero extension.
// Latency: combinational; backpressure: none.
module tiny_riscv_lsu_align
  import tiny_riscv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_mask = 4'b0000;
    st_data = st_wdata;
    case (st_funct3)
      F3_B: begin
        st_mask = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_mask = 4'b0011 << {st_off[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      F3_W:    st_mask = 4'b1111;
      default: st_mask = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/tiny_riscv_lsu.sv
// RV32I load/store unit to a 1-cycle synchronous word memory; TINY_RISCV_LSU_MISALIGN_TRAP_EN faults misaligned H/W.
// Latency: load done 2 edges, store 1 edge, fault 0 edges after accept; backpressure: o_ready low while busy.
module tiny_riscv_lsu
  import tiny_riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 6144
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  tiny_riscv_lsu_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  lsu_state_e            state_q, state_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rstb_q, rstb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;

  logic [1:0]  req_off;
  logic        req_fault;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  always_comb begin
    req_off   = eff_offset(bus.i_funct3, bus.i_addr[1:0]);
    req_fault = !f3_supported(bus.i_we, bus.i_funct3) || (bus.i_addr >= MEM_LIMIT);
`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
    req_fault = req_fault || is_misaligned(bus.i_funct3, bus.i_addr[1:0]);
`endif
  end

  // Store lanes come from the live request; load extraction uses the latched request.
  tiny_riscv_lsu_align u_align (
    .st_funct3 (bus.i_funct3),
    .st_off    (req_off),
    .st_wdata  (bus.i_wdata),
    .st_mask   (st_mask),
    .st_data   (st_data),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (bus.i_mem_data),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    rstb_d     = 1'b0;
    wdata_d    = wdata_q;
    mask_d     = 4'b0000;
    f3_d       = f3_q;
    off_d      = off_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          if (req_fault) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            mem_addr_d = {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
            f3_d       = bus.i_funct3;
            off_d      = req_off;
            if (bus.i_we) begin
              mask_d  = st_mask;
              wdata_d = st_data;
              state_d = ST_ST_ISSUE;
            end else begin
              rstb_d  = 1'b1;
              state_d = ST_LD_ISSUE;
            end
          end
        end
      end
      ST_LD_ISSUE: state_d = ST_LD_WAIT;
      ST_LD_WAIT: begin
        rdata_d = ld_data;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ST_ISSUE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      rstb_q     <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      rstb_q     <= rstb_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
    end
  end

  assign bus.o_ready          = (state_q == ST_IDLE);
  assign bus.o_done           = done_q;
  assign bus.o_fault          = fault_q;
  assign bus.o_rdata          = rdata_q;
  assign bus.o_mem_addr       = mem_addr_q;
  assign bus.o_read_strobe    = rstb_q;
  assign bus.o_mem_write_data = wdata_q;
  assign bus.o_mem_write_mask = mask_q;

endmodule

// File: tb/tb_tiny_riscv_lsu.sv
// Bench for tiny_riscv_lsu: byte-array memory behind the DUT, byte-level reference model, directed + random ops.
module tb_tiny_riscv_lsu;

  localparam int AW = 32;
  localparam int MB = 6144;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tiny_riscv_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  tiny_riscv_lsu #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  logic [7:0]  mem     [MB];
  logic [7:0]  ref_mem [MB];
  logic        mem_loaded = 1'b0;
  logic [31:0] last_rd = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Word memory: 1-cycle synchronous read, per-byte write mask.
  always @(posedge clk) begin
    int a;
    if (!mem_loaded) begin
      for (int i = 0; i < MB; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else begin
      a = int'(bus.o_mem_addr);
      if (a <= MB - 4) begin
        if (bus.o_read_strobe)
          bus.i_mem_data <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        for (int l = 0; l < 4; l++)
          if (bus.o_mem_write_mask[l]) mem[a+l] <= bus.o_mem_write_data[8*l +: 8];
      end
    end
  end

  // Byte-level model of one request; updates ref_mem on stores, last_rd on loads.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic ef, output logic [31:0] erd,
                          output logic [3:0] emask, output logic [31:0] ewd);
    int a;
    logic bad, mis;
    bad = we ? (f3 > 3'd2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis = ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 2'b00);
    ef = bad || (addr >= MB);
`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
    ef = ef || mis;
`else
    mis = 1'b0;
`endif
    erd = last_rd; emask = 4'h0; ewd = 32'h0;
    if (!ef) begin
      a = int'(addr);
      if (f3 == 1 || f3 == 5) a = a - a % 2;
      if (f3 == 2) a = a - a % 4;
      if (we) begin
        if (f3 == 0) begin
          emask = 4'(1 << (a % 4)); ewd = {4{wd[7:0]}}; ref_mem[a] = wd[7:0];
        end else if (f3 == 1) begin
          emask = 4'(3 << (a % 4)); ewd = {2{wd[15:0]}};
          ref_mem[a] = wd[7:0]; ref_mem[a+1] = wd[15:8];
        end else begin
          emask = 4'hF; ewd = wd;
          for (int i = 0; i < 4; i++) ref_mem[a+i] = wd[8*i +: 8];
        end
      end else begin
        if (f3 == 0 || f3 == 4) begin
          erd = 32'(ref_mem[a]);
          if (f3 == 0 && erd[7]) erd = erd | 32'hFFFF_FF00;
        end else if (f3 == 1 || f3 == 5) begin
          erd = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 256;
          if (f3 == 1 && erd[15]) erd = erd | 32'hFFFF_0000;
        end else begin
          erd = 0;
          for (int i = 3; i >= 0; i--) erd = erd * 256 + 32'(ref_mem[a+i]);
        end
        last_rd = erd;
      end
    end
  endtask

  // Drive one request from a negedge; returns at the negedge where o_done is seen (or after a bounded wait).
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic flt, output logic [31:0] rd, output logic [3:0] mask,
                        output logic [31:0] mwd, output logic strb, output logic ovl, output logic rdy0,
                        output logic [3:0] mask_end);
    rdy0 = bus.o_ready;
    bus.i_req = 1'b1; bus.i_we = we; bus.i_funct3 = f3; bus.i_addr = addr; bus.i_wdata = wd;
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.i_we = 1'($urandom); bus.i_funct3 = 3'($urandom);
    bus.i_addr = $urandom; bus.i_wdata = $urandom;
    lat = -1; flt = 1'b0; rd = 32'h0; mask = 4'h0; mwd = 32'h0; strb = 1'b0; ovl = 1'b0; mask_end = 4'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.o_read_strobe) strb = 1'b1;
      if (bus.o_mem_write_mask != 4'h0) begin
        mask = bus.o_mem_write_mask; mwd = bus.o_mem_write_data;
        if (bus.o_read_strobe) ovl = 1'b1;
      end
      if (bus.o_done) begin
        lat = n - 1; flt = bus.o_fault; rd = bus.o_rdata; mask_end = bus.o_mem_write_mask;
        break;
      end
    end
  endtask

  int lat; logic flt, strb, ovl, rdy0, ef; logic [31:0] rd, mwd, erd, ewd; logic [3:0] mask, mask_end, emask;

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.o_done, bus.o_fault, bus.o_read_strobe, bus.o_mem_write_mask} !== 7'h0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.o_done, bus.o_fault, bus.o_read_strobe, bus.o_mem_write_mask}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
    n_checks++;
    if ({bus.o_rdata, bus.o_mem_addr, bus.o_mem_write_data} !== 96'h0)
      begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", bus.o_rdata, bus.o_mem_addr, bus.o_mem_write_data); end
    @(negedge clk);
  endtask

  task automatic test_word();
    model_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, ef, erd, emask, ewd);
    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, mask, mwd, mask_end} !== {32'd1, 1'b0, 4'hF, 32'hDEADBEEF, 4'h0})
      begin n_fail++; $display("FAIL sw: lat=%0d flt=%b mask=%h data=%h end=%h want 1 0 f deadbeef 0", lat, flt, mask, mwd, mask_end); end
    model_op(1'b0, 3'b010, 32'h100, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, strb, rd} !== {32'd2, 1'b0, 1'b1, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL lw: lat=%0d flt=%b strb=%b rd=%h want 2 0 1 deadbeef", lat, flt, strb, rd); end
  endtask

  task automatic test_byte_half();
    model_op(1'b1, 3'b000, 32'h102, 32'h80, ef, erd, emask, ewd);
    run_op(1'b1, 3'b000, 32'h102, 32'h80, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, mask, mwd} !== {32'd1, 4'b0100, 32'h80808080})
      begin n_fail++; $display("FAIL sb: lat=%0d mask=%b data=%h want 1 0100 80808080", lat, mask, mwd); end
    model_op(1'b0, 3'b000, 32'h102, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b000, 32'h102, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", rd); end
    model_op(1'b0, 3'b100, 32'h102, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b100, 32'h102, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", rd); end
    model_op(1'b1, 3'b001, 32'h106, 32'h8001, ef, erd, emask, ewd);
    run_op(1'b1, 3'b001, 32'h106, 32'h8001, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({mask, mwd} !== {4'b1100, 32'h80018001}) begin n_fail++; $display("FAIL sh: mask=%b data=%h want 1100 80018001", mask, mwd); end
    model_op(1'b0, 3'b001, 32'h106, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b001, 32'h106, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", rd); end
    model_op(1'b0, 3'b101, 32'h106, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b101, 32'h106, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h want 00008001", rd); end
  endtask

  task automatic test_misalign();
    model_op(1'b0, 3'b010, 32'h101, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b010, 32'h101, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
`ifdef TINY_RISCV_LSU_MISALIGN_TRAP_EN
    n_checks++;
    if ({lat, flt, strb, rd} !== {32'd0, 1'b1, 1'b0, 32'h00008001})
      begin n_fail++; $display("FAIL lw_mis: lat=%0d flt=%b strb=%b rd=%h want 0 1 0 00008001", lat, flt, strb, rd); end
`else
    n_checks++;
    if ({lat, flt, strb, rd} !== {32'd2, 1'b0, 1'b1, 32'hDE80BEEF})
      begin n_fail++; $display("FAIL lw_mis: lat=%0d flt=%b strb=%b rd=%h want 2 0 1 de80beef", lat, flt, strb, rd); end
`endif
  endtask

  task automatic test_fault_bounds();
    logic [31:0] held;
    held = last_rd;
    model_op(1'b0, 3'b010, 32'h1800, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b010, 32'h1800, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, strb, rd} !== {32'd0, 1'b1, 1'b0, held})
      begin n_fail++; $display("FAIL lw_oob: lat=%0d flt=%b strb=%b rd=%h want 0 1 0 %h", lat, flt, strb, rd, held); end
    model_op(1'b0, 3'b011, 32'h100, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b011, 32'h100, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, strb} !== {32'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ld_f3_011: lat=%0d flt=%b strb=%b want 0 1 0", lat, flt, strb); end
    model_op(1'b1, 3'b100, 32'h100, 32'h12345678, ef, erd, emask, ewd);
    run_op(1'b1, 3'b100, 32'h100, 32'h12345678, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, mask} !== {32'd0, 1'b1, 4'h0}) begin n_fail++; $display("FAIL st_f3_100: lat=%0d flt=%b mask=%h want 0 1 0", lat, flt, mask); end
    model_op(1'b0, 3'b010, 32'h17FC, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b010, 32'h17FC, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({lat, flt, rd} !== {32'd2, 1'b0, erd}) begin n_fail++; $display("FAIL lw_top: lat=%0d flt=%b rd=%h want 2 0 %h", lat, flt, rd, erd); end
    model_op(1'b0, 3'b100, 32'h17FF, 32'h0, ef, erd, emask, ewd);
    run_op(1'b0, 3'b100, 32'h17FF, 32'h0, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
    n_checks++;
    if ({flt, rd} !== {1'b0, erd}) begin n_fail++; $display("FAIL lbu_last: flt=%b rd=%h want 0 %h", flt, rd, erd); end
  endtask

  task automatic test_reset_mid_store();
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'b000; bus.i_addr = 32'h200; bus.i_wdata = 32'h5A;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    n_checks++;
    if (bus.o_mem_write_mask !== 4'b0001) begin n_fail++; $display("FAIL rst_st_mask_before: got %b want 0001", bus.o_mem_write_mask); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_mem_write_mask !== 4'b0000) begin n_fail++; $display("FAIL rst_st_mask_async: got %b want 0000", bus.o_mem_write_mask); end
    @(negedge clk);
    n_checks++;
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL rst_st_done: got %b want 0", bus.o_done); end
    rst_n = 1'b1; last_rd = 32'h0;
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_st_ready: got %b want 1", bus.o_ready); end
    n_checks++;
    if (mem[32'h200] !== ref_mem[32'h200]) begin n_fail++; $display("FAIL rst_st_mem: got %h want %h", mem[32'h200], ref_mem[32'h200]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [31:0] addr, wd; int exp_lat;
    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3) f3 = 3'd5;
      end
      addr = ($urandom_range(0, 9) < 8) ? 32'h300 + $urandom_range(0, 63) : 32'h17F8 + $urandom_range(0, 15);
      wd = $urandom;
      model_op(we, f3, addr, wd, ef, erd, emask, ewd);
      exp_lat = ef ? 0 : (we ? 1 : 2);
      run_op(we, f3, addr, wd, lat, flt, rd, mask, mwd, strb, ovl, rdy0, mask_end);
      n_checks++;
      if ({lat, flt} !== {exp_lat, ef}) begin n_fail++; $display("FAIL rnd%0d_lat: we=%b f3=%0d a=%h lat=%0d flt=%b want %0d %b", i, we, f3, addr, lat, flt, exp_lat, ef); end
      n_checks++;
      if (rd !== erd) begin n_fail++; $display("FAIL rnd%0d_rdata: we=%b f3=%0d a=%h got %h want %h", i, we, f3, addr, rd, erd); end
      n_checks++;
      if ({mask, mwd} !== {emask, ewd}) begin n_fail++; $display("FAIL rnd%0d_wr: got %b/%h want %b/%h", i, mask, mwd, emask, ewd); end
      n_checks++;
      if ({strb, ovl, rdy0, mask_end} !== {(!ef && !we), 1'b0, 1'b1, 4'h0})
        begin n_fail++; $display("FAIL rnd%0d_ctl: strb=%b ovl=%b rdy=%b end=%b want %b 0 1 0", i, strb, ovl, rdy0, mask_end, (!ef && !we)); end
    end
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_fault_bounds();
    test_reset_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_riscv_lsu.md
Name: tiny_riscv_lsu

Overview:
Load/store unit between the CPU execute stage and the word-wide data memory, which has a 1-cycle synchronous read and per-byte write mask.
- Converts one RV32I load/store request into a word address, read strobe, or byte write mask plus lane-shifted write data.
- Aligns and sign/zero-extends the returned load word.
- Reports completion with a one-cycle done pulse.
- The memory handles endianness: lane 0 is bits 7:0 and is byte address +0.

Parameters:
ADDR_WIDTH, 32, width of byte address ports.
MEM_BYTES, 6144, size of the backing memory in bytes. Any access whose byte address is >= MEM_BYTES faults.

Ports:
i_Clk  in  1  clock
i_Rst_L  in  1  asynchronous active-low reset
i_req  in  1  request valid, sampled only while o_ready=1
i_we  in  1  1=store, 0=load
i_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  in  ADDR_WIDTH  byte address
i_wdata  in  32  store data, LSB-justified
o_ready  out  1  1 in IDLE
o_done  out  1  one-cycle completion pulse
o_fault  out  1  valid with o_done; access rejected
o_rdata  out  32  extended load result, valid with o_done
o_mem_addr  out  ADDR_WIDTH  byte address to memory, low 2 bits forced 0
o_read_strobe  out  1  memory read strobe
o_mem_write_data  out  32  lane-shifted store data
o_mem_write_mask  out  4  byte-lane write enables
i_mem_data  in  32  memory read word, valid the cycle after the strobe edge

Behaviour:
- Clock and reset: one clock i_Clk; asynchronous active-low reset i_Rst_L.
- Reset (asynchronous, i_Rst_L=0):
  - state=IDLE.
  - All registered outputs 0: o_done, o_fault, o_rdata, o_mem_addr, o_read_strobe, o_mem_write_data, o_mem_write_mask.
  - Reset mid-operation drops any pending strobe/mask immediately; the write is aborted and no done pulse is produced.
- States: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE. o_ready = (state==IDLE).
- Accept at edge E0 when i_req && o_ready. All request fields are latched; later input changes are ignored.
- Fault check at accept:
  - Unsupported funct3 (load 011/110/111; store 011..111).
  - Address >= MEM_BYTES.
  - Misalignment (see Optional Feature).
  - On fault: no strobe or mask. o_done=o_fault=1 for the cycle after E0. o_rdata is held. State stays IDLE.
- Load:
  - E0: o_mem_addr={addr[hi:2],2'b00}, o_read_strobe=1, go to LD_ISSUE.
  - E1: strobe drops, go to LD_WAIT.
  - E2: o_rdata is set from i_mem_data, o_done=1, go to IDLE.
  - o_done is high for the cycle after E2. Latency is 2 edges.
- Load extraction, with byte offset k=addr[1:0]:
  - B/BU: lane k, sign- or zero-extended.
  - H/HU: bits [16*addr[1] +: 16], extended.
  - W: whole word.
- Store:
  - E0: mask and lane-shifted data are registered, go to ST_ISSUE.
    - B: mask=4'b0001<<k, data = byte replicated in all 4 lanes.
    - H: mask=4'b0011<<(2*addr[1]), data = halfword replicated in both halves.
    - W: mask=1111, data = i_wdata.
  - E1: memory writes, mask and strobe clear, o_done=1, go to IDLE.
- Pulse rules: o_done and o_fault pulse for exactly one cycle. A new request may be accepted in the same cycle o_done is high.
- Masks are never nonzero while o_read_strobe=1.
- Address MEM_BYTES-1 is in range; an access at MEM_BYTES faults. There is no wrap-around.

Optional Feature:
TINY_RISCV_LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, faults as described above.
- Undefined: misaligned requests are not faulted. Offending low bits are cleared (H uses addr[1]; W uses offset 0) and the access proceeds normally.

Decomposition:
- Shared package tiny_riscv_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - LSU state encoding.
- One natural sub-module: tiny_riscv_lsu_align, purely combinational. It does store lane shift and mask generation, and load extract/extend. The FSM and registers stay in the top module.

Test Plan:
- Reset asserted mid-ST_ISSUE with mask 0001 -> mask drops to 0 asynchronously; no o_done; memory word unchanged; o_ready=1 after release.
- SW 0xDEADBEEF @0x100, then LW @0x100 -> store o_done 1 edge after accept with mask 1111; load o_done 2 edges later with o_rdata=0xDEADBEEF.
- SB 0x80 @0x102, then LB @0x102 / LBU @0x102 -> mask 0100 with data 0x80808080; loads return 0xFFFFFF80 / 0x00000080.
- SH 0x8001 @0x106, then LH @0x106 -> mask 1100; o_rdata=0xFFFF8001. LHU returns 0x00008001.
- LW @0x101 -> with macro: o_done=o_fault=1 one cycle after accept, no strobe. Without macro: reads word 0x100, o_fault=0.
- LW @MEM_BYTES (0x1800) and funct3=011 load -> o_fault=1, no strobe. LW @0x17FC succeeds.
